// File: rtl/kmeans_pipeline_param.sv
// K-means assignment pipeline: per-centroid squared distance, adder tree, then min-select tree.
// Accepts one sample per cycle with fixed latency; writable centroid bank and saturating hit counters.
module kmeans_pipeline_param #(
    parameter  int DATA_WIDTH = 16,
    parameter  int DIMENSIONS = 2,
    parameter  int CENTROIDS  = 3,
    parameter  int CNT_WIDTH  = 32,
    localparam int IDW        = (CENTROIDS > 1) ? $clog2(CENTROIDS) : 1,
    localparam int DIMW       = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1,
    localparam int SW         = 2 * DATA_WIDTH + $clog2(DIMENSIONS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cent_wr_en,
    input  logic [IDW-1:0]                   cent_wr_k,
    input  logic [DIMW-1:0]                  cent_wr_d,
    input  logic [DATA_WIDTH-1:0]            cent_wr_data,
    input  logic                             in_valid,
    input  logic [DIMENSIONS*DATA_WIDTH-1:0] in_data,
    input  logic                             cnt_clear,
    output logic                             out_valid,
    output logic [DIMENSIONS*DATA_WIDTH-1:0] out_data,
    output logic [IDW-1:0]                   out_centroid,
    output logic [SW-1:0]                    out_distance,
    output logic [CENTROIDS*CNT_WIDTH-1:0]   hit_counts
);

    localparam int DW     = DATA_WIDTH;
    localparam int ADD_LV = $clog2(DIMENSIONS);
    localparam int CMP_LV = $clog2(CENTROIDS);
    localparam int LAT    = 2 + ADD_LV + CMP_LV;
    localparam int SMPW   = DIMENSIONS * DW;

    // Number of live operands at a given level of a halving tree with n leaves.
    function automatic int cnt_at(input int n, input int lvl);
        int c;
        c = n;
        for (int j = 0; j < lvl; j++) c = (c + 1) / 2;
        return c;
    endfunction

    function automatic int clamp_idx(input int v, input int n);
        return (v < n) ? v : 0;
    endfunction

    function automatic logic [2*DW-1:0] square(input logic [DW-1:0] a);
        return (2 * DW)'(a) * (2 * DW)'(a);
    endfunction

    logic [DW-1:0]    smp      [DIMENSIONS];
    logic [DW-1:0]    cent_q   [CENTROIDS][DIMENSIONS];
    logic [DW-1:0]    diff_q   [CENTROIDS][DIMENSIONS];
    logic [SW-1:0]    add_q    [CENTROIDS][ADD_LV+1][DIMENSIONS];
    logic [SW-1:0]    src_d    [CMP_LV][CENTROIDS];
    logic [IDW-1:0]   src_i    [CMP_LV][CENTROIDS];
    logic [SW-1:0]    nxt_d    [CMP_LV+1][CENTROIDS];
    logic [IDW-1:0]   nxt_i    [CMP_LV+1][CENTROIDS];
    logic [SW-1:0]    cmp_d_q  [CMP_LV][CENTROIDS];
    logic [IDW-1:0]   cmp_i_q  [CMP_LV][CENTROIDS];
    logic [LAT-1:0]   vld_q;
    logic [SMPW-1:0]  data_q   [LAT-1];
    logic [SMPW-1:0]  out_data_q;
    logic [IDW-1:0]   out_centroid_q;
    logic [SW-1:0]    out_distance_q;
    logic [CNT_WIDTH-1:0] hit_q [CENTROIDS];

    for (genvar d = 0; d < DIMENSIONS; d++) begin : g_unpack
        assign smp[d] = in_data[d*DW +: DW];
    end

    // Writes land at the clock edge, so a sample entering in the same cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CENTROIDS; k++)
                for (int d = 0; d < DIMENSIONS; d++)
                    cent_q[k][d] <= '0;
        end else if (cent_wr_en && (32'(cent_wr_k) < CENTROIDS) && (32'(cent_wr_d) < DIMENSIONS)) begin
            cent_q[cent_wr_k][cent_wr_d] <= cent_wr_data;
        end
    end

    // NOTE: datapath registers carry no reset; validity is tracked solely by vld_q.
    always_ff @(posedge clk) begin
        for (int k = 0; k < CENTROIDS; k++) begin
            for (int d = 0; d < DIMENSIONS; d++) begin
                diff_q[k][d]   <= (cent_q[k][d] >= smp[d]) ? cent_q[k][d] - smp[d] : smp[d] - cent_q[k][d];
                add_q[k][0][d] <= SW'(square(diff_q[k][d]));
            end
            for (int l = 1; l <= ADD_LV; l++) begin
                for (int i = 0; i < DIMENSIONS; i++) begin
                    add_q[k][l][i] <=
                        ((2*i     < cnt_at(DIMENSIONS, l-1)) ? add_q[k][l-1][clamp_idx(2*i, DIMENSIONS)]     : '0) +
                        ((2*i + 1 < cnt_at(DIMENSIONS, l-1)) ? add_q[k][l-1][clamp_idx(2*i + 1, DIMENSIONS)] : '0);
                end
            end
        end
        for (int l = 0; l < CMP_LV; l++) begin
            for (int i = 0; i < CENTROIDS; i++) begin
                cmp_d_q[l][i] <= nxt_d[l][i];
                cmp_i_q[l][i] <= nxt_i[l][i];
            end
        end
        data_q[0] <= in_data;
        for (int s = 1; s < LAT - 1; s++) data_q[s] <= data_q[s-1];
    end

    // Level 0 of the compare tree is the adder-tree root; deeper levels come from cmp_*_q.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        for (int l = 0; l <= CMP_LV; l++) begin
            for (int i = 0; i < CENTROIDS; i++) begin
                nxt_d[l][i] = '0;
                nxt_i[l][i] = '0;
            end
        end
        for (int l = 0; l < CMP_LV; l++) begin
            for (int i = 0; i < CENTROIDS; i++) begin
                src_d[l][i] = (l == 0) ? add_q[i][ADD_LV][0] : cmp_d_q[l][i];
                src_i[l][i] = (l == 0) ? IDW'(i) : cmp_i_q[l][i];
            end
        end
        for (int l = 1; l <= CMP_LV; l++) begin
            for (int i = 0; i < CENTROIDS; i++) begin
                if (2*i + 1 < cnt_at(CENTROIDS, l-1)) begin
                    // a <= b keeps the lower index on ties.
                    if (src_d[l-1][clamp_idx(2*i, CENTROIDS)] <= src_d[l-1][clamp_idx(2*i + 1, CENTROIDS)]) begin
                        nxt_d[l][i] = src_d[l-1][clamp_idx(2*i, CENTROIDS)];
                        nxt_i[l][i] = src_i[l-1][clamp_idx(2*i, CENTROIDS)];
                    end else begin
                        nxt_d[l][i] = src_d[l-1][clamp_idx(2*i + 1, CENTROIDS)];
                        nxt_i[l][i] = src_i[l-1][clamp_idx(2*i + 1, CENTROIDS)];
                    end
                end else if (2*i < cnt_at(CENTROIDS, l-1)) begin
                    nxt_d[l][i] = src_d[l-1][clamp_idx(2*i, CENTROIDS)];
                    nxt_i[l][i] = src_i[l-1][clamp_idx(2*i, CENTROIDS)];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages advance together.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q          <= '0;
            out_data_q     <= '0;
            out_centroid_q <= '0;
            out_distance_q <= '0;
        end else begin
            vld_q <= {vld_q[LAT-2:0], in_valid};
            if (vld_q[LAT-2]) begin
                out_data_q     <= data_q[LAT-2];
                out_centroid_q <= nxt_i[CMP_LV][0];
                out_distance_q <= nxt_d[CMP_LV][0];
            end
        end
    end

    // Clear outranks a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            for (int k = 0; k < CENTROIDS; k++) hit_q[k] <= '0;
        end else begin
            for (int k = 0; k < CENTROIDS; k++) begin
                if (vld_q[LAT-1] && (out_centroid_q == IDW'(k)) && (hit_q[k] != '1))
                    hit_q[k] <= hit_q[k] + CNT_WIDTH'(1);
            end
        end
    end

    for (genvar k = 0; k < CENTROIDS; k++) begin : g_hits
        assign hit_counts[k*CNT_WIDTH +: CNT_WIDTH] = hit_q[k];
    end

    assign out_valid    = vld_q[LAT-1];
    assign out_data     = out_data_q;
    assign out_centroid = out_centroid_q;
    assign out_distance = out_distance_q;

endmodule

// File: tb/tb_kmeans_pipeline_param.sv
// Directed bench for kmeans_pipeline_param: default instance, a 3-bit counter instance and a K=5/D=3 instance.
module tb_kmeans_pipeline_param;

    localparam int LAT  = 2 + $clog2(2) + $clog2(3);
    localparam int LAT5 = 2 + $clog2(3) + $clog2(5);

    logic        clk = 1'b0;
    logic        rst, rst_c;
    logic        cent_wr_en, in_valid, cnt_clear;
    logic [1:0]  cent_wr_k;
    logic [0:0]  cent_wr_d;
    logic [15:0] cent_wr_data;
    logic [31:0] in_data;

    logic        out_valid, out_valid_c;
    logic [31:0] out_data, out_data_c;
    logic [1:0]  out_centroid, out_centroid_c;
    logic [32:0] out_distance, out_distance_c;
    logic [95:0] hit_counts;
    logic [8:0]  hit_counts_c;

    logic        cent_wr_en5, in_valid5;
    logic [2:0]  cent_wr_k5;
    logic [1:0]  cent_wr_d5;
    logic [15:0] cent_wr_data5;
    logic [47:0] in_data5, out_data5;
    logic        out_valid5;
    logic [2:0]  out_centroid5;
    logic [33:0] out_distance5;
    logic [159:0] hit_counts5;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kmeans_pipeline_param dut (
        .clk(clk), .rst(rst), .cent_wr_en(cent_wr_en), .cent_wr_k(cent_wr_k), .cent_wr_d(cent_wr_d),
        .cent_wr_data(cent_wr_data), .in_valid(in_valid), .in_data(in_data), .cnt_clear(cnt_clear),
        .out_valid(out_valid), .out_data(out_data), .out_centroid(out_centroid),
        .out_distance(out_distance), .hit_counts(hit_counts)
    );

    kmeans_pipeline_param #(.CNT_WIDTH(3)) dut_c (
        .clk(clk), .rst(rst_c), .cent_wr_en(cent_wr_en), .cent_wr_k(cent_wr_k), .cent_wr_d(cent_wr_d),
        .cent_wr_data(cent_wr_data), .in_valid(in_valid), .in_data(in_data), .cnt_clear(cnt_clear),
        .out_valid(out_valid_c), .out_data(out_data_c), .out_centroid(out_centroid_c),
        .out_distance(out_distance_c), .hit_counts(hit_counts_c)
    );

    kmeans_pipeline_param #(.DIMENSIONS(3), .CENTROIDS(5)) dut5 (
        .clk(clk), .rst(rst), .cent_wr_en(cent_wr_en5), .cent_wr_k(cent_wr_k5), .cent_wr_d(cent_wr_d5),
        .cent_wr_data(cent_wr_data5), .in_valid(in_valid5), .in_data(in_data5), .cnt_clear(1'b0),
        .out_valid(out_valid5), .out_data(out_data5), .out_centroid(out_centroid5),
        .out_distance(out_distance5), .hit_counts(hit_counts5)
    );

    typedef struct packed {
        logic [15:0] c00, c01, c10, c11, c20, c21, x0, x1;
        logic [1:0]  ek;
        logic [63:0] ed;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input int c00, input int c01, input int c10, input int c11, input int c20,
                                input int c21, input int x0, input int x1, input int ek, input longint ed);
        vec_t v;
        v.c00 = 16'(c00); v.c01 = 16'(c01); v.c10 = 16'(c10); v.c11 = 16'(c11);
        v.c20 = 16'(c20); v.c21 = 16'(c21); v.x0 = 16'(x0); v.x1 = 16'(x1);
        v.ek = 2'(ek); v.ed = 64'(ed);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cent(input int k, input int d, input int v);
        cent_wr_en = 1'b1; cent_wr_k = 2'(k); cent_wr_d = 1'(d); cent_wr_data = 16'(v);
        tick();
        cent_wr_en = 1'b0;
    endtask

    task automatic set_cents(input int c00, input int c01, input int c10, input int c11, input int c20, input int c21);
        wr_cent(0, 0, c00); wr_cent(0, 1, c01);
        wr_cent(1, 0, c10); wr_cent(1, 1, c11);
        wr_cent(2, 0, c20); wr_cent(2, 1, c21);
    endtask

    task automatic run_sample(input string tag, input int x0, input int x1, input int ek, input logic [63:0] ed);
        in_valid = 1'b1; in_data = {16'(x1), 16'(x0)};
        tick();
        in_valid = 1'b0;
        repeat (LAT - 2) tick();
        check({tag, "_early"}, 64'(out_valid), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_idx"}, 64'(out_centroid), 64'(ek));
        check({tag, "_dist"}, 64'(out_distance), ed);
        check({tag, "_data"}, 64'(out_data), 64'({16'(x1), 16'(x0)}));
        tick();
        check({tag, "_pulse"}, 64'(out_valid), 64'd0);
        check({tag, "_hold"}, 64'(out_distance), ed);
    endtask

    task automatic wr_cent5(input int k, input int d, input int v);
        cent_wr_en5 = 1'b1; cent_wr_k5 = 3'(k); cent_wr_d5 = 2'(d); cent_wr_data5 = 16'(v);
        tick();
        cent_wr_en5 = 1'b0;
    endtask

    task automatic run_sample5(input string tag, input int x0, input int x1, input int x2, input int ek,
                               input logic [63:0] ed);
        in_valid5 = 1'b1; in_data5 = {16'(x2), 16'(x1), 16'(x0)};
        tick();
        in_valid5 = 1'b0;
        repeat (LAT5 - 2) tick();
        check({tag, "_early"}, 64'(out_valid5), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(out_valid5), 64'd1);
        check({tag, "_idx"}, 64'(out_centroid5), 64'(ek));
        check({tag, "_dist"}, 64'(out_distance5), ed);
        check({tag, "_data"}, 64'(out_data5), 64'({16'(x2), 16'(x1), 16'(x0)}));
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] pat;
        int         exp_d4 [10];
        int         base5 [5];

        vecs[0] = mk(0, 0, 10, 10, 100, 100, 12, 9, 1, 5);
        vecs[1] = mk(0, 0, 4, 0, 50, 50, 2, 0, 0, 4);
        vecs[2] = mk(65535, 65535, 65535, 65535, 65535, 65535, 0, 0, 0, 64'h1_FFFC_0002);
        vecs[3] = mk(1, 0, 1000, 1000, 2000, 2000, 3, 0, 0, 4);
        vecs[4] = mk(0, 0, 10, 10, 100, 100, 200, 50, 2, 12500);
        vecs[5] = mk(0, 0, 10, 0, 20, 0, 15, 0, 1, 25);
        vecs[6] = mk(7, 7, 8, 8, 9, 9, 9, 9, 2, 0);
        pat    = 10'b1101100111;
        exp_d4 = '{5, 4, 0, 8, 13, 0, 0, 36, 49, 64};
        base5  = '{0, 10, 100, 200, 300};

        rst = 1'b1; rst_c = 1'b1;
        cent_wr_en = 1'b0; cent_wr_k = '0; cent_wr_d = '0; cent_wr_data = '0;
        in_valid = 1'b0; in_data = '0; cnt_clear = 1'b0;
        cent_wr_en5 = 1'b0; cent_wr_k5 = '0; cent_wr_d5 = '0; cent_wr_data5 = '0;
        in_valid5 = 1'b0; in_data5 = '0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_idx", 64'(out_centroid), 64'd0);
        check("rst_dist", 64'(out_distance), 64'd0);
        check("rst_hits_lo", hit_counts[63:0], 64'd0);
        check("rst_hits_hi", 64'(hit_counts[95:64]), 64'd0);
        check("rst_c_hits", 64'(hit_counts_c), 64'd0);
        check("rst5_valid", 64'(out_valid5), 64'd0);
        check("rst5_dist", 64'(out_distance5), 64'd0);

        for (int i = 0; i < 7; i++) begin
            set_cents(vecs[i].c00, vecs[i].c01, vecs[i].c10, vecs[i].c11, vecs[i].c20, vecs[i].c21);
            run_sample($sformatf("vec%0d", i), vecs[i].x0, vecs[i].x1, vecs[i].ek, vecs[i].ed);
        end
        check("hits_table_k0", 64'(hit_counts[0 +: 32]), 64'd3);
        check("hits_table_k1", 64'(hit_counts[32 +: 32]), 64'd2);
        check("hits_table_k2", 64'(hit_counts[64 +: 32]), 64'd2);

        // Gapped stream with a centroid-1 write landing alongside sample 4.
        set_cents(0, 0, 10, 10, 100, 100);
        repeat (LAT) tick();
        for (int c = 0; c < 15; c++) begin
            if (c >= 5 && pat[9 - (c - 5)]) begin
                check($sformatf("t4_valid_c%0d", c), 64'(out_valid), 64'd1);
                check($sformatf("t4_idx_c%0d", c), 64'(out_centroid), 64'd1);
                check($sformatf("t4_dist_c%0d", c), 64'(out_distance), 64'(exp_d4[c - 5]));
                check($sformatf("t4_data_c%0d", c), 64'(out_data), 64'({16'(9 + c - 5), 16'd12}));
            end else begin
                check($sformatf("t4_idle_c%0d", c), 64'(out_valid), 64'd0);
            end
            in_valid = (c < 10) ? pat[9 - ((c < 10) ? c : 0)] : 1'b0;
            in_data  = {16'(9 + c), 16'd12};
            cent_wr_en = (c == 4); cent_wr_k = 2'd1; cent_wr_d = 1'd0; cent_wr_data = 16'd12;
            tick();
            cent_wr_en = 1'b0;
        end
        check("t4_hits_k1", 64'(hit_counts[32 +: 32]), 64'd9);

        // Saturating 3-bit counters and clear priority.
        rst_c = 1'b0;
        tick();
        wr_cent(2, 0, 5); wr_cent(2, 1, 5);
        in_valid = 1'b1; in_data = {16'd5, 16'd5};
        repeat (2) tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("t5_hits2_two", 64'(hit_counts_c[6 +: 3]), 64'd2);
        check("t5_hits0_zero", 64'(hit_counts_c[0 +: 3]), 64'd0);
        in_valid = 1'b1;
        repeat (7) tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("t5_hits2_sat", 64'(hit_counts_c[6 +: 3]), 64'd7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        check("t5_clr_valid", 64'(out_valid_c), 64'd1);
        check("t5_clr_idx", 64'(out_centroid_c), 64'd2);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        check("t5_clr_hits2", 64'(hit_counts_c[6 +: 3]), 64'd0);
        check("t5_clr_all", 64'(hit_counts_c), 64'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (LAT + 1) tick();
        check("t5_after_clr", 64'(hit_counts_c[6 +: 3]), 64'd1);

        // Reset with samples in flight.
        set_cents(0, 0, 10, 10, 100, 100);
        in_valid = 1'b1; in_data = {16'd9, 16'd12};
        repeat (3) tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_data", 64'(out_data), 64'd0);
        check("t6_rst_idx", 64'(out_centroid), 64'd0);
        check("t6_rst_dist", 64'(out_distance), 64'd0);
        check("t6_rst_hits", hit_counts[63:0] | 64'(hit_counts[95:64]), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t6_no_valid_%0d", i), 64'(out_valid), 64'd0);
            tick();
        end
        run_sample("t6_zero_cents", 12, 9, 0, 225);

        // K=5, D=3 instance, including ignored out-of-range writes.
        for (int k = 0; k < 5; k++)
            for (int d = 0; d < 3; d++)
                wr_cent5(k, d, base5[k]);
        wr_cent5(7, 0, 1);
        wr_cent5(0, 3, 50000);
        run_sample5("k5_t1", 12, 9, 10, 1, 5);
        run_sample5("k5_idx3", 210, 190, 200, 3, 200);
        run_sample5("k5_idx4", 300, 300, 301, 4, 1);
        run_sample5("k5_idx0", 1, 2, 0, 0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
